// File: rtl/word_scan_serializer.sv
// Serialises words first..last (wrapping mod 32) from an external 32x64 mux, one bit per handshake.
// Latency: start -> first bit 3 cycles, 2-cycle gap between words; SCAN_PARITY_EN adds a parity bit per word.
// Backpressure: dout/sof hold while dout_ready=0; a bit advances only when dout_valid & dout_ready.
module word_scan_serializer #(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [4:0]  first,
    input  logic [4:0]  last,
    output logic [5:0]  select,
    input  logic [63:0] din,
    output logic        dout,
    output logic        dout_valid,
    input  logic        dout_ready,
    output logic        sof,
    output logic        busy,
    output logic        done
);

`ifdef SCAN_PARITY_EN
    typedef enum logic [2:0] {IDLE, SEL, LOAD, SHIFT, PAR, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, SEL, LOAD, SHIFT, DONE} state_t;
`endif

    state_t      state_q, state_d;
    logic [4:0]  idx_q;
    logic [4:0]  last_q;
    logic [63:0] sreg_q;
    logic [6:0]  bcnt_q;
    logic        xfer;
    logic        eow;
`ifdef SCAN_PARITY_EN
    logic        par_q;
`endif

    assign xfer = dout_valid & dout_ready;

    always_ff @(posedge clk) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        eow     = 1'b0;
        case (state_q)
            IDLE:  if (start) state_d = SEL;
            SEL:   state_d = LOAD;
            LOAD:  state_d = SHIFT;
            SHIFT: begin
                if (xfer && bcnt_q == 7'd63) begin
`ifdef SCAN_PARITY_EN
                    state_d = PAR;
`else
                    eow = 1'b1;
`endif
                end
            end
`ifdef SCAN_PARITY_EN
            PAR:   if (xfer) eow = 1'b1;
`endif
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (eow) state_d = (idx_q == last_q) ? DONE : SEL;
    end

    always_comb begin
        select     = 6'd0;
        dout       = 1'b0;
        dout_valid = 1'b0;
        sof        = 1'b0;
        busy       = (state_q != IDLE);
        done       = (state_q == DONE);
        case (state_q)
            SEL, LOAD: select = {1'b0, idx_q};
            SHIFT: begin
                select     = {1'b0, idx_q};
                dout_valid = 1'b1;
                dout       = MSB_FIRST ? sreg_q[63] : sreg_q[0];
                sof        = (bcnt_q == 7'd0);
            end
`ifdef SCAN_PARITY_EN
            PAR: begin
                select     = {1'b0, idx_q};
                dout_valid = 1'b1;
                dout       = par_q;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            idx_q  <= 5'd0;
            last_q <= 5'd0;
            sreg_q <= 64'd0;
            bcnt_q <= 7'd0;
`ifdef SCAN_PARITY_EN
            par_q  <= 1'b0;
`endif
        end else begin
            // first/last are only captured here, so start while busy cannot disturb a scan
            if (state_q == IDLE && start) begin
                idx_q  <= first;
                last_q <= last;
            end
            if (state_q == LOAD) begin
                sreg_q <= din;
                bcnt_q <= 7'd0;
`ifdef SCAN_PARITY_EN
                par_q  <= ^din;
`endif
            end
            if (state_q == SHIFT && xfer) begin
                sreg_q <= MSB_FIRST ? (sreg_q << 1) : (sreg_q >> 1);
                bcnt_q <= bcnt_q + 7'd1;
            end
            // 5-bit add wraps 31 -> 0 for first > last scans
            if (eow && idx_q != last_q) idx_q <= idx_q + 5'd1;
        end
    end

endmodule
